// File: rtl/rand_pkg.sv
// Shared types and widths for the rand_range rejection sampler.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int REJ_CNT_W = 16;
  // Spacing counter holds W-1 <= 7; try counter holds MAX_TRIES-1 <= 254.
  localparam int SPACE_W   = 3;
  localparam int TRY_W     = 8;

endpackage

// File: rtl/rand_range.sv
// Rejection sampler: turns W fresh LFSR bits per evaluation into a uniform value in
// [0, RANGE-1], folding into range after MAX_TRIES rejections and flagging it with err.
module rand_range
  import rand_pkg::*;
#(
  parameter int RANGE     = 6,
  parameter int MAX_TRIES = 16,
  localparam int W        = $clog2(RANGE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          rnd_in,
  input  logic                 req,
  input  logic                 ready,
  output logic                 busy,
  output logic                 valid,
  output logic [W-1:0]         value,
  output logic                 err,
  output logic [REJ_CNT_W-1:0] reject_cnt
);

  localparam int WP1 = W + 1;
  localparam logic [SPACE_W-1:0] SPACE_LOAD = SPACE_W'(W - 1);
  localparam logic [TRY_W-1:0]   LAST_TRY   = TRY_W'(MAX_TRIES - 1);
  localparam logic [WP1-1:0]     RANGE_C    = WP1'(RANGE);

  state_e                 state_q;
  logic [SPACE_W-1:0]     space_q;
  logic [TRY_W-1:0]       try_q;
  logic [W-1:0]           value_q;
  logic                   err_q;
  logic [REJ_CNT_W-1:0]   rej_cnt_q;
  logic [REJ_CNT_W-1:0]   rej_cnt_d;

  logic [W-1:0]           s;
  logic [W-1:0]           s_fold;
  logic                   accept;
  logic                   unused_rnd;

  assign s          = rnd_in[W-1:0];
  assign accept     = {1'b0, s} < RANGE_C;
  // Only reached when s >= RANGE, so the difference is already below RANGE.
  assign s_fold     = s - RANGE_C[W-1:0];
  assign unused_rnd = &{1'b0, rnd_in[31:W]};

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (rej_cnt_q != '1) begin
      rej_cnt_d = rej_cnt_q + REJ_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      space_q   <= '0;
      try_q     <= '0;
      value_q   <= '0;
      err_q     <= 1'b0;
      rej_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= SAMPLE;
            space_q <= SPACE_LOAD;
            try_q   <= '0;
          end
        end
        SAMPLE: begin
          if (space_q != '0) begin
            space_q <= space_q - SPACE_W'(1);
          end else if (accept) begin
            value_q <= s;
            err_q   <= 1'b0;
            state_q <= HOLD;
          end else begin
            rej_cnt_q <= rej_cnt_d;
            if (try_q == LAST_TRY) begin
              value_q <= s_fold;
              err_q   <= 1'b1;
              state_q <= HOLD;
            end else begin
              try_q   <= try_q + TRY_W'(1);
              space_q <= SPACE_LOAD;
            end
          end
        end
        HOLD: begin
          if (ready) begin
            if (req) begin
              state_q <= SAMPLE;
              space_q <= SPACE_LOAD;
              try_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign valid      = (state_q == HOLD);
  assign value      = value_q;
  assign err        = err_q;
  assign reject_cnt = rej_cnt_q;

endmodule

// File: tb/tb_rand_range.sv
// Scoreboard bench for rand_range (RANGE=6, MAX_TRIES=4): directed vectors plus an LFSR soak.
module tb_rand_range;

  logic        clk;
  logic        rst;
  logic [31:0] rnd_in;
  logic        req;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [2:0]  value;
  logic        err;
  logic [15:0] reject_cnt;

  typedef struct packed {
    logic        any;
    logic [2:0]  value;
    logic        err;
    logic [15:0] rej;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  rand_range #(.RANGE(6), .MAX_TRIES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd_in     (rnd_in),
    .req        (req),
    .ready      (ready),
    .busy       (busy),
    .valid      (valid),
    .value      (value),
    .err        (err),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic any, input logic [2:0] v, input logic e, input logic [15:0] r);
    exp_t x;
    x.any   = any;
    x.value = v;
    x.err   = e;
    x.rej   = r;
    sb_q.push_back(x);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // Monitor: every handshake pops one expected result.
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.any) begin
          check("lfsr_range", 32'(value < 3'd6), 32'd1);
        end else begin
          check("sb_value", 32'(value), 32'(mon_e.value));
          check("sb_err", 32'(err), 32'(mon_e.err));
          check("sb_reject_cnt", 32'(reject_cnt), 32'(mon_e.rej));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   got;
    int   cyc;
    logic seen;
    logic [31:0] hold_pat [5];
    hold_pat = '{32'h7, 32'h0, 32'h5, 32'h2, 32'h1};

    rst    = 1'b0;
    req    = 1'b0;
    ready  = 1'b0;
    rnd_in = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_reject_cnt", 32'(reject_cnt), 32'd0);
    rst = 1'b1;

    // Accept on first evaluation: value 4 after the 3rd edge.
    rnd_in = 32'h4;
    req    = 1'b1;
    push(1'b0, 3'd4, 1'b0, 16'd0);
    tick();
    req = 1'b0;
    check("acc_busy_e0", 32'(busy), 32'd1);
    tick();
    tick();
    check("acc_valid_e2", 32'(valid), 32'd0);
    tick();
    check("acc_valid_e3", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    check("acc_valid_after_hs", 32'(valid), 32'd0);
    check("acc_idle_after_hs", 32'(busy), 32'd0);
    ready = 1'b0;

    // Reject 7 once, then accept 2 at the 6th edge.
    rnd_in = 32'h7;
    req    = 1'b1;
    push(1'b0, 3'd2, 1'b0, 16'd1);
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    rnd_in = 32'h2;
    tick();
    tick();
    check("rej_valid_e5", 32'(valid), 32'd0);
    tick();
    check("rej_valid_e6", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Backpressure: HOLD keeps value 3 while rnd_in toggles and req pulses.
    rnd_in = 32'h3;
    req    = 1'b1;
    push(1'b0, 3'd3, 1'b0, 16'd1);
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      rnd_in = hold_pat[i];
      req    = (i % 2 == 0);
      tick();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_value", 32'(value), 32'd3);
      check("bp_err", 32'(err), 32'd0);
    end
    req   = 1'b0;
    ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    tick();
    check("bp_stays_idle", 32'(busy), 32'd0);
    ready = 1'b0;

    // Fresh reset, then fallback: four rejections of 7 give value 1 with err.
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rnd_in = 32'h7;
    req    = 1'b1;
    push(1'b0, 3'd1, 1'b1, 16'd4);
    tick();
    req = 1'b0;
    repeat (11) tick();
    check("fb_valid_e11", 32'(valid), 32'd0);
    tick();
    check("fb_valid_e12", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Second fallback, then an asynchronous reset mid-HOLD abandons it.
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (12) tick();
    check("fb2_valid", 32'(valid), 32'd1);
    check("fb2_err", 32'(err), 32'd1);
    check("fb2_reject_cnt", 32'(reject_cnt), 32'd8);
    #2;
    rst = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_value", 32'(value), 32'd0);
    check("async_err", 32'(err), 32'd0);
    check("async_reject_cnt", 32'(reject_cnt), 32'd0);
    tick();
    rst   = 1'b1;
    ready = 1'b1;
    seen  = 1'b0;
    repeat (15) begin
      tick();
      if (valid || busy) seen = 1'b1;
    end
    check("no_result_after_reset", 32'(seen), 32'd0);
    ready = 1'b0;

    // Back-to-back: req held across the handshake restarts SAMPLE immediately.
    rnd_in = 32'h4;
    req    = 1'b1;
    push(1'b0, 3'd4, 1'b0, 16'd0);
    push(1'b0, 3'd4, 1'b0, 16'd0);
    tick();
    tick();
    tick();
    tick();
    check("b2b_first_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    check("b2b_hs_valid", 32'(valid), 32'd0);
    check("b2b_hs_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("b2b_valid_h2", 32'(valid), 32'd0);
    tick();
    check("b2b_valid_h3", 32'(valid), 32'd1);
    req = 1'b0;
    tick();
    check("b2b_end_idle", 32'(busy), 32'd0);

    // LFSR soak: 256 back-to-back results, each must lie in [0, 5].
    for (int i = 0; i < 256; i++) push(1'b1, 3'd0, 1'b0, 16'd0);
    rnd_in = 32'hACE1_1234;
    req    = 1'b1;
    ready  = 1'b1;
    got    = 0;
    cyc    = 0;
    while (got < 256 && cyc < 20000) begin
      @(negedge clk);
      if (valid) begin
        got++;
        if (got == 256) req = 1'b0;
      end
      @(posedge clk);
      #1;
      rnd_in = lfsr_step(rnd_in);
      cyc++;
    end
    check("lfsr_result_count", 32'(got), 32'd256);
    req = 1'b0;
    repeat (15) tick();
    check("lfsr_queue_drained", 32'(sb_q.size()), 32'd0);
    check("lfsr_end_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rand_range.md
RAND_RANGE -- requirements
Module: rand_range

Interface
REQ-001 Parameter RANGE, default 6: size of output range [0, RANGE-1]; legal 2..256.
REQ-002 Parameter MAX_TRIES, default 16: evaluations per request before fallback; legal 1..255.
REQ-003 Derived constant W = clog2(RANGE): width of value and of the sampled bit field.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 rnd_in  input  32  pseudo-random word from the upstream LFSR stage q output, one new shift per cycle.
REQ-007 req  input  1  request for one random number; level sampled in IDLE only.
REQ-008 ready  input  1  downstream accepts value when high with valid.
REQ-009 busy  output  1  high in SAMPLE and HOLD.
REQ-010 valid  output  1  value holds a result awaiting handshake.
REQ-011 value  output  W  result, always < RANGE while valid.
REQ-012 err  output  1  qualifies value: result came from fallback after MAX_TRIES rejections.
REQ-013 reject_cnt  output  16  saturating count of rejected evaluations since reset.

Function
REQ-014 FSM states IDLE, SAMPLE, HOLD; IDLE after reset.
REQ-015 IDLE: req=1 at an edge -> SAMPLE, spacing counter loaded W-1, try counter cleared.
REQ-016 SAMPLE: spacing counter nonzero -> decrement only; zero -> evaluate s = rnd_in[W-1:0].
REQ-017 Evaluation therefore occurs at the W-th rising edge after the edge accepting req, so each evaluation sees W fresh LFSR bits.
REQ-018 s < RANGE -> value=s, err=0, go HOLD.
REQ-019 s >= RANGE and try counter < MAX_TRIES-1 -> increment try counter, reload spacing counter W-1, stay SAMPLE.
REQ-020 s >= RANGE and try counter = MAX_TRIES-1 -> value = s - RANGE, err=1, go HOLD; s - RANGE < RANGE holds since s < 2^W <= 2*RANGE.
REQ-021 Every evaluation with s >= RANGE, including the fallback one, increments reject_cnt; reject_cnt holds at 16'hFFFF.
REQ-022 RANGE a power of two: every evaluation accepts; err never asserts.
REQ-023 HOLD: valid=1; value and err stable regardless of rnd_in; req ignored.
REQ-024 HOLD with ready=1: handshake; req=0 -> IDLE, valid low next cycle; req=1 -> SAMPLE directly (back-to-back), as in REQ-015.
REQ-025 ready while not valid has no effect; no combinational path from ready or req to any output.
REQ-026 value and err retain last result after handshake until overwritten.

Reset
REQ-027 rst low forces asynchronously: state IDLE, busy=0, valid=0, value=0, err=0, reject_cnt=0, both counters 0.
REQ-028 Reset mid-SAMPLE or mid-HOLD abandons the request; no result is delivered after reset release.
REQ-029 First request accepted at the first rising edge with rst high and req high.

Structure
REQ-030 Package rand_pkg holds the state enum typedef (IDLE, SAMPLE, HOLD) and the reject_cnt width constant (16).
REQ-031 Single module, no sub-module; spacing counter, try counter and FSM are inline.

Verification
REQ-032 Reset: rst low mid-operation -> busy=0, valid=0, value=0, err=0, reject_cnt=0 immediately, without a clock edge.
REQ-033 Accept, RANGE=6: rnd_in[2:0]=3'b100 constant, req one cycle -> valid high after 3rd edge, value=4, err=0, reject_cnt=0.
REQ-034 Reject then accept: rnd_in[2:0]=7 through first evaluation, then 2 -> valid after 6th edge, value=2, err=0, reject_cnt=1.
REQ-035 Fallback, MAX_TRIES=4: rnd_in[2:0]=7 always -> valid after 12th edge, value=1, err=1, reject_cnt=4.
REQ-036 Backpressure: ready=0 for 5 cycles in HOLD while rnd_in toggles and req pulses -> value, err constant, no new request; ready=1 with req=0 -> valid low next cycle, state IDLE.
REQ-037 Back-to-back: req held high across handshake -> SAMPLE entered at handshake edge, next valid 3 edges later; 256 results with a real LFSR on rnd_in all < 6.
